// File: rtl/ttl_aoi_pkg.sv
// Shared mode encodings and parameter limits for the clocked AND-OR-INVERT block.
package ttl_aoi_pkg;

  localparam logic [1:0] MODE_REG    = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_STICKY = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int GROUPS_MIN = 1;
  localparam int GROUPS_MAX = 8;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 8;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int CNT_W_MIN  = 2;
  localparam int CNT_W_MAX  = 16;

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ttl_aoi_core.sv
// Combinational GROUPS x WIDTH AND-NOR; a disabled group contributes 0 to the OR.
module ttl_aoi_core
  import ttl_aoi_pkg::*;
#(
  parameter int GROUPS = 2,
  parameter int WIDTH  = 4
) (
  input  logic [GROUPS*WIDTH-1:0] i_a,
  input  logic [GROUPS-1:0]       i_grp_en,
  output logic                    o_nor
);

  logic [GROUPS-1:0] w_and;

  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
      assign w_and[gi] = (&i_a[gi*WIDTH +: WIDTH]) & i_grp_en[gi];
    end
  endgenerate

  assign o_nor = ~|w_and;

endmodule

// File: rtl/ttl_aoi_seq.sv
// Clocked AND-NOR: pipeline of the gate result, mode-selected output stage
// (REG / TOGGLE / STICKY) and a falling-edge counter on the pipeline tail.
module ttl_aoi_seq
  import ttl_aoi_pkg::*;
#(
  parameter int GROUPS = 2,
  parameter int WIDTH  = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [GROUPS*WIDTH-1:0] a,
  input  logic [GROUPS-1:0]       grp_en,
  input  logic                    ce,
  input  logic [1:0]              mode,
  output logic                    y_comb,
  output logic                    y,
  output logic                    y_n,
  output logic                    valid,
  output logic [CNT_W-1:0]        fall_cnt,
  output logic                    cnt_ovf
);

  generate
    if (!(in_range(GROUPS, GROUPS_MIN, GROUPS_MAX) && in_range(WIDTH, WIDTH_MIN, WIDTH_MAX) &&
          in_range(STAGES, STAGES_MIN, STAGES_MAX) && in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)))
    begin : g_param_err
      $error("ttl_aoi_seq: parameter out of range");
    end
  endgenerate

  localparam logic [2:0] FILL_FULL = 3'(STAGES);

  logic              w_nor;
  logic [STAGES:0]   w_chain;
  logic              w_tail;
  logic              w_tail_next;
  logic              w_y_next;
  logic              w_fall;
  logic [STAGES-1:0] r_pipe;
  logic [2:0]        r_fill;
  logic              r_y;
  logic [1:0]        r_last_mode;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  ttl_aoi_core #(.GROUPS(GROUPS), .WIDTH(WIDTH)) u_core (
    .i_a      (a),
    .i_grp_en (grp_en),
    .o_nor    (w_nor)
  );

  // Head of the chain is the live gate; bit STAGES-1 is what the tail becomes after this edge.
  assign w_chain     = {r_pipe, w_nor};
  assign w_tail      = w_chain[STAGES];
  assign w_tail_next = w_chain[STAGES-1];
  assign valid       = (r_fill == FILL_FULL);
  assign w_fall      = w_tail & ~w_tail_next;

  always_comb begin
    w_y_next = r_y;
    if (mode != r_last_mode) begin
      w_y_next = w_tail_next;
    end else begin
      case (mode)
        MODE_TOGGLE:         if (!w_tail_next) w_y_next = ~r_y;
        MODE_STICKY:         if (!w_tail_next) w_y_next = 1'b0;
        MODE_REG, MODE_RSVD: w_y_next = w_tail_next;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pipe      <= '1;
      r_fill      <= 3'd0;
      r_y         <= 1'b1;
      r_last_mode <= MODE_REG;
    end else if (ce) begin
      r_pipe      <= w_chain[STAGES-1:0];
      r_last_mode <= mode;
      if (!valid) r_fill <= r_fill + 3'd1;
      if (valid)  r_y    <= w_y_next;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (ce && valid && w_fall) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (&r_cnt) r_ovf <= 1'b1;
    end
  end

  assign y_comb   = w_nor;
  assign y        = r_y;
  assign y_n      = ~r_y;
  assign fall_cnt = r_cnt;
  assign cnt_ovf  = r_ovf;

endmodule
